ckpt_ctrl: RTL and testbench
============================

# ckpt_ctrl

Checkpoint controller that drives the backup/restore side of a bank of NREG dirty-tracked registers for intermittent computing. On a backup request it invalidates the stored checkpoint, copies every register whose dirty state is non-clean into non-volatile memory (NVM), acknowledges each copied register, then writes a commit key. On a restore request it checks the commit key and, if valid, reloads every register from NVM through the registers' restore path. It sits between the power monitor, the NVM port and the register bank; the core is stalled while Busy is high.

## Interface
- NREG, 8, number of managed registers
- N, 32, register and NVM word width
- AW, 4, NVM address width; must satisfy 2^AW > NREG
- COMMIT_KEY, 32'hA5A5_5A5A, commit word value (N bits)

- Clk  in  1  clock, all state on rising edge
- Rst  in  1  asynchronous, active-low reset
- Pwr_off  in  1  simulated power loss; synchronous abort to IDLE, same output values as reset
- Backup_req  in  1  backup request, sampled only in IDLE
- Restore_req  in  1  restore request, sampled only in IDLE
- Dirty_val  in  2*NREG  register i state at [2i+1:2i]; 2'b00 = clean, any other value = must save
- Backup_Vout  in  N*NREG  register i value at [N*i+N-1:N*i]
- Backup_en  out  1  high for the whole backup sequence
- Backup_ack  out  NREG  one-cycle pulse on bit i when register i is saved
- Restore_en  out  NREG  one-cycle pulse on bit i to load Restore_Vin into register i
- Restore_Vin  out  N  restore data, registered
- Nvm_req, Nvm_we  out  1  NVM request; write when Nvm_we=1
- Nvm_addr  out  AW  word address; register i at i, commit word at NREG
- Nvm_wdata  out  N  write data
- Nvm_rdata  in  N  read data, valid when Nvm_ready=1
- Nvm_ready  in  1  transfer completes on an edge where Nvm_req=1 and Nvm_ready=1
- Busy  out  1  sequence in progress
- Backup_done, Restore_done  out  1  one-cycle completion pulses
- Restore_valid  out  1  result of last restore (1 = checkpoint loaded), held until next restore

## Operation
- States: IDLE, B_INV, B_SCAN, B_WRITE, B_COMMIT, R_CHECK, R_READ, DONE.
- IDLE: Restore_req has priority over Backup_req when both high. Requests arriving while Busy are ignored (not queued).
- B_INV: write 0 to address NREG. Then ptr=0, B_SCAN.
- B_SCAN (1 cycle per index): if Dirty_val[i]!=0 go B_WRITE, else ptr++; after ptr=NREG-1 go B_COMMIT.
- B_WRITE: write Backup_Vout[i] to address i; on completion pulse Backup_ack[i] in the following cycle, ptr++, back to B_SCAN (or B_COMMIT if last).
- B_COMMIT: write COMMIT_KEY to NREG; then DONE with Backup_done.
- R_CHECK: read NREG; if rdata==COMMIT_KEY, ptr=0, R_READ; else DONE, Restore_valid=0.
- R_READ: read address i; on completion latch rdata into Restore_Vin and pulse Restore_en[i] the next cycle (Restore_Vin stable that cycle); after i=NREG-1 go DONE, Restore_valid=1.
- DONE: one cycle, done pulse, Busy=0, return to IDLE.
- Nvm_addr/we/wdata constant while Nvm_req high and not yet accepted; Nvm_req drops in the cycle after completion, not re-asserted to the same address.
- Dirty_val and Backup_Vout are sampled at the B_SCAN/B_WRITE cycle of their index; core must not write registers while Busy.

## Timing
- Reset / Pwr_off: state IDLE, ptr 0, every output 0 including Restore_Vin and Restore_valid. Mid-sequence abort leaves NVM with commit word 0 or partial data; a later restore then reports Restore_valid=0 unless B_COMMIT completed.
- Busy rises the cycle after request acceptance edge.
- Nvm_ready tied high, k dirty registers: backup Busy = 2+NREG+k cycles, Backup_done the cycle after; restore Busy = 1+NREG cycles (valid) or 1 cycle (invalid).
- Each Nvm_ready stall cycle extends latency by exactly one cycle.
- At most one bit of Backup_ack/Restore_en high in any cycle.

## Test plan
- Reset with Rst=0 mid-B_WRITE -> all outputs 0, next Backup_req starts at B_INV writing 0 to address 8.
- NREG=8, Dirty_val with registers 2 and 5 non-clean, ready high -> writes addr 8←0, 2, 5, 8←A5A55A5A; Backup_ack pulses 2 then 5; Busy 12 cycles; Backup_done once.
- All clean -> only B_INV and commit writes, no Backup_ack, Busy 10 cycles.
- Restore with NVM addr 8=A5A55A5A, addr i=i*16'h1111 -> Restore_en[i] pulses in order 0..7 with Restore_Vin=i*16'h1111, Restore_valid=1.
- Restore with addr 8=0 -> no Restore_en, Restore_done pulse, Restore_valid=0.
- Backup_req and Restore_req together; Nvm_ready low 3 cycles per access; Pwr_off mid-restore -> restore chosen, signals held stable during stalls, Pwr_off returns to IDLE with outputs 0.

Source files
------------

// File: rtl/ckpt_ctrl.sv
// Checkpoint controller: saves dirty registers to NVM behind an invalidate/commit
// key pair, and reloads them on restore when the commit key is present.
module ckpt_ctrl #(
  parameter int NREG = 8,
  parameter int N    = 32,
  parameter int AW   = 4,
  parameter logic [N-1:0] COMMIT_KEY = 32'hA5A5_5A5A
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                Pwr_off,
  input  logic                Backup_req,
  input  logic                Restore_req,
  input  logic [2*NREG-1:0]   Dirty_val,
  input  logic [N*NREG-1:0]   Backup_Vout,
  output logic                Backup_en,
  output logic [NREG-1:0]     Backup_ack,
  output logic [NREG-1:0]     Restore_en,
  output logic [N-1:0]        Restore_Vin,
  output logic                Nvm_req,
  output logic                Nvm_we,
  output logic [AW-1:0]       Nvm_addr,
  output logic [N-1:0]        Nvm_wdata,
  input  logic [N-1:0]        Nvm_rdata,
  input  logic                Nvm_ready,
  output logic                Busy,
  output logic                Backup_done,
  output logic                Restore_done,
  output logic                Restore_valid
);

  typedef enum logic [2:0] {
    IDLE, B_INV, B_SCAN, B_WRITE, B_COMMIT, R_CHECK, R_READ, DONE
  } state_t;

  state_t          state, state_n;
  logic [AW-1:0]   ptr, ptr_n;
  logic            mode, mode_n;   // 1 = restore sequence in flight
  logic [NREG-1:0] ack_n, en_n;
  logic [N-1:0]    vin_n;
  logic            valid_n;
  logic            xfer, last;
  logic [1:0]      dirty_cur;
  int              idx;

  assign idx       = int'(ptr);
  assign last      = (ptr == AW'(NREG - 1));
  assign xfer      = Nvm_req & Nvm_ready;
  assign dirty_cur = 2'(Dirty_val >> (2 * idx));

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state         <= IDLE;
      ptr           <= '0;
      mode          <= 1'b0;
      Backup_ack    <= '0;
      Restore_en    <= '0;
      Restore_Vin   <= '0;
      Restore_valid <= 1'b0;
    end else begin
      state         <= state_n;
      ptr           <= ptr_n;
      mode          <= mode_n;
      Backup_ack    <= ack_n;
      Restore_en    <= en_n;
      Restore_Vin   <= vin_n;
      Restore_valid <= valid_n;
    end
  end

  always_comb begin
    state_n      = state;
    ptr_n        = ptr;
    mode_n       = mode;
    ack_n        = '0;
    en_n         = '0;
    vin_n        = Restore_Vin;
    valid_n      = Restore_valid;
    Nvm_req      = 1'b0;
    Nvm_we       = 1'b0;
    Nvm_addr     = '0;
    Nvm_wdata    = '0;
    Backup_en    = 1'b0;
    Busy         = 1'b0;
    Backup_done  = 1'b0;
    Restore_done = 1'b0;

    case (state)
      IDLE: begin
        if (Restore_req) begin
          mode_n  = 1'b1;
          state_n = R_CHECK;
        end else if (Backup_req) begin
          mode_n  = 1'b0;
          state_n = B_INV;
        end
      end
      B_INV: begin
        // Kill the old commit word first so a torn backup never looks valid.
        Busy = 1'b1; Backup_en = 1'b1;
        Nvm_req = 1'b1; Nvm_we = 1'b1; Nvm_addr = AW'(NREG);
        if (xfer) begin
          ptr_n   = '0;
          state_n = B_SCAN;
        end
      end
      B_SCAN: begin
        Busy = 1'b1; Backup_en = 1'b1;
        if (dirty_cur != 2'b00) state_n = B_WRITE;
        else if (last) begin
          ptr_n   = '0;
          state_n = B_COMMIT;
        end else ptr_n = ptr + 1'b1;
      end
      B_WRITE: begin
        Busy = 1'b1; Backup_en = 1'b1;
        Nvm_req = 1'b1; Nvm_we = 1'b1; Nvm_addr = ptr;
        Nvm_wdata = N'(Backup_Vout >> (N * idx));
        if (xfer) begin
          ack_n = NREG'(1) << ptr;
          if (last) begin
            ptr_n   = '0;
            state_n = B_COMMIT;
          end else begin
            ptr_n   = ptr + 1'b1;
            state_n = B_SCAN;
          end
        end
      end
      B_COMMIT: begin
        Busy = 1'b1; Backup_en = 1'b1;
        Nvm_req = 1'b1; Nvm_we = 1'b1; Nvm_addr = AW'(NREG);
        Nvm_wdata = COMMIT_KEY;
        if (xfer) state_n = DONE;
      end
      R_CHECK: begin
        Busy = 1'b1;
        Nvm_req = 1'b1; Nvm_addr = AW'(NREG);
        if (xfer) begin
          if (Nvm_rdata == COMMIT_KEY) begin
            ptr_n   = '0;
            state_n = R_READ;
          end else begin
            valid_n = 1'b0;
            state_n = DONE;
          end
        end
      end
      R_READ: begin
        Busy = 1'b1;
        Nvm_req = 1'b1; Nvm_addr = ptr;
        if (xfer) begin
          vin_n = Nvm_rdata;
          en_n  = NREG'(1) << ptr;
          if (last) begin
            ptr_n   = '0;
            valid_n = 1'b1;
            state_n = DONE;
          end else ptr_n = ptr + 1'b1;
        end
      end
      DONE: begin
        Backup_done  = ~mode;
        Restore_done = mode;
        state_n      = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Power loss behaves like reset on the next edge.
    if (Pwr_off) begin
      state_n = IDLE;
      ptr_n   = '0;
      mode_n  = 1'b0;
      ack_n   = '0;
      en_n    = '0;
      vin_n   = '0;
      valid_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_ckpt_ctrl.sv
// Directed bench for ckpt_ctrl with a behavioural NVM that can stall 3 cycles per access.
module tb_ckpt_ctrl;
  localparam int NREG = 8;
  localparam int N    = 32;
  localparam int AW   = 4;
  localparam logic [N-1:0] KEY = 32'hA5A5_5A5A;

  logic              Clk = 1'b0;
  logic              Rst = 1'b0;
  logic              Pwr_off = 1'b0;
  logic              Backup_req = 1'b0;
  logic              Restore_req = 1'b0;
  logic [2*NREG-1:0] Dirty_val = '0;
  logic [N*NREG-1:0] Backup_Vout = '0;
  logic              Backup_en;
  logic [NREG-1:0]   Backup_ack, Restore_en;
  logic [N-1:0]      Restore_Vin;
  logic              Nvm_req, Nvm_we;
  logic [AW-1:0]     Nvm_addr;
  logic [N-1:0]      Nvm_wdata, Nvm_rdata;
  logic              Nvm_ready;
  logic              Busy, Backup_done, Restore_done, Restore_valid;

  ckpt_ctrl #(.NREG(NREG), .N(N), .AW(AW), .COMMIT_KEY(KEY)) dut (
    .Clk(Clk), .Rst(Rst), .Pwr_off(Pwr_off), .Backup_req(Backup_req),
    .Restore_req(Restore_req), .Dirty_val(Dirty_val), .Backup_Vout(Backup_Vout),
    .Backup_en(Backup_en), .Backup_ack(Backup_ack), .Restore_en(Restore_en),
    .Restore_Vin(Restore_Vin), .Nvm_req(Nvm_req), .Nvm_we(Nvm_we),
    .Nvm_addr(Nvm_addr), .Nvm_wdata(Nvm_wdata), .Nvm_rdata(Nvm_rdata),
    .Nvm_ready(Nvm_ready), .Busy(Busy), .Backup_done(Backup_done),
    .Restore_done(Restore_done), .Restore_valid(Restore_valid)
  );

  always #5 Clk = ~Clk;

  // NVM model: optional 3-cycle stall per access, write log for ordering checks.
  logic [N-1:0]  mem [16];
  logic [AW-1:0] wa [256];
  logic [N-1:0]  wd [256];
  int            wr_n = 0;
  int            cnt = 0;
  logic          stall = 1'b0;

  assign Nvm_ready = !stall || (cnt == 3);
  assign Nvm_rdata = mem[Nvm_addr];

  initial for (int i = 0; i < 16; i++) mem[i] = '0;

  always @(posedge Clk) begin
    if (!Nvm_req || Nvm_ready) cnt <= 0;
    else cnt <= cnt + 1;
    if (Nvm_req && Nvm_ready && Nvm_we) begin
      mem[Nvm_addr]   <= Nvm_wdata;
      wa[wr_n & 255]  <= Nvm_addr;
      wd[wr_n & 255]  <= Nvm_wdata;
      wr_n            <= wr_n + 1;
    end
  end

  logic [90:0] outs;
  assign outs = {Busy, Backup_en, Backup_ack, Restore_en, Restore_Vin, Nvm_req, Nvm_we,
                 Nvm_addr, Nvm_wdata, Backup_done, Restore_done, Restore_valid};

  int checks = 0, errors = 0;
  int busy_cnt, bdone_cnt, rdone_cnt, multi_hot, w0;
  int ack_q[$], en_q[$];
  logic [N-1:0] vin_q[$];

  task automatic clr();
    busy_cnt = 0; bdone_cnt = 0; rdone_cnt = 0;
    ack_q.delete(); en_q.delete(); vin_q.delete();
    w0 = wr_n;
  endtask

  // Advance one cycle and sample outputs on the falling edge.
  task automatic step();
    @(negedge Clk);
    if (Busy) busy_cnt++;
    if (Backup_done) bdone_cnt++;
    if (Restore_done) rdone_cnt++;
    if ($countones(Backup_ack) > 1 || $countones(Restore_en) > 1) multi_hot++;
    for (int i = 0; i < NREG; i++) begin
      if (Backup_ack[i]) ack_q.push_back(i);
      if (Restore_en[i]) begin en_q.push_back(i); vin_q.push_back(Restore_Vin); end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge Clk);
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs got %h exp 0", outs); end
    Rst = 1'b1;
    step();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL idle_outs got %h exp 0", outs); end
  endtask

  task automatic test_reset_mid_write();
    Dirty_val = 16'h5555;
    Backup_req = 1'b1; step(); Backup_req = 1'b0;
    step(); step();
    checks++;
    if ({Nvm_req, Nvm_we, Nvm_addr} !== {1'b1, 1'b1, 4'd0}) begin
      errors++; $display("FAIL in_bwrite got %b exp 1_1_0000", {Nvm_req, Nvm_we, Nvm_addr});
    end
    #1 Rst = 1'b0;
    #1;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL async_rst_outs got %h exp 0", outs); end
    @(negedge Clk);
    Rst = 1'b1; Dirty_val = '0; Backup_req = 1'b1; clr();
    step(); Backup_req = 1'b0;
    checks++;
    if ({Busy, Nvm_req, Nvm_we, Nvm_addr, Nvm_wdata} !== {1'b1, 1'b1, 1'b1, 4'd8, 32'h0}) begin
      errors++; $display("FAIL restart_binv got %h", {Busy, Nvm_req, Nvm_we, Nvm_addr, Nvm_wdata});
    end
    repeat (14) step();
  endtask

  task automatic test_backup_two_dirty();
    Dirty_val = 16'h0C10;
    for (int i = 0; i < NREG; i++) Backup_Vout[N*i +: N] = 32'h1000_0000 + i;
    clr();
    Backup_req = 1'b1; step(); Backup_req = 1'b0;
    repeat (19) step();
    checks++;
    if (busy_cnt !== 12) begin errors++; $display("FAIL two_busy got %0d exp 12", busy_cnt); end
    checks++;
    if (bdone_cnt !== 1) begin errors++; $display("FAIL two_done got %0d exp 1", bdone_cnt); end
    checks++;
    if (ack_q.size() != 2 || ack_q[0] != 2 || ack_q[1] != 5) begin
      errors++; $display("FAIL two_ack got %p exp 2,5", ack_q);
    end
    checks++;
    if (wr_n - w0 != 4 || wa[w0&255] != 8 || wd[w0&255] != 0 || wa[(w0+1)&255] != 2 ||
        wd[(w0+1)&255] != 32'h1000_0002 || wa[(w0+2)&255] != 5 ||
        wd[(w0+2)&255] != 32'h1000_0005 || wa[(w0+3)&255] != 8 || wd[(w0+3)&255] != KEY) begin
      errors++; $display("FAIL two_writes got count %0d exp 4 ordered 8,2,5,8", wr_n - w0);
    end
  endtask

  task automatic test_all_clean();
    Dirty_val = '0; clr();
    Backup_req = 1'b1; step(); Backup_req = 1'b0;
    repeat (15) step();
    checks++;
    if (busy_cnt !== 10) begin errors++; $display("FAIL clean_busy got %0d exp 10", busy_cnt); end
    checks++;
    if (ack_q.size() != 0 || bdone_cnt != 1) begin
      errors++; $display("FAIL clean_ack_done got acks %0d done %0d exp 0 1", ack_q.size(), bdone_cnt);
    end
    checks++;
    if (wr_n - w0 != 2 || wd[w0&255] != 0 || wa[(w0+1)&255] != 8 || wd[(w0+1)&255] != KEY) begin
      errors++; $display("FAIL clean_writes got count %0d exp 2", wr_n - w0);
    end
  endtask

  task automatic test_backup_all();
    Dirty_val = 16'hAAAA;
    for (int i = 0; i < NREG; i++) Backup_Vout[N*i +: N] = i * 32'h1111;
    clr();
    Backup_req = 1'b1; step(); Backup_req = 1'b0;
    repeat (23) step();
    checks++;
    if (busy_cnt !== 18) begin errors++; $display("FAIL all_busy got %0d exp 18", busy_cnt); end
    checks++;
    if (ack_q.size() != 8 || ack_q[0] != 0 || ack_q[7] != 7 || bdone_cnt != 1) begin
      errors++; $display("FAIL all_ack got %p exp 0..7", ack_q);
    end
  endtask

  task automatic test_restore_valid();
    clr();
    Restore_req = 1'b1; step(); Restore_req = 1'b0;
    repeat (14) step();
    checks++;
    if (busy_cnt !== 9) begin errors++; $display("FAIL rv_busy got %0d exp 9", busy_cnt); end
    checks++;
    if (rdone_cnt !== 1) begin errors++; $display("FAIL rv_done got %0d exp 1", rdone_cnt); end
    checks++;
    if (Restore_valid !== 1'b1) begin errors++; $display("FAIL rv_valid got %b exp 1", Restore_valid); end
    checks++;
    if (en_q.size() != 8) begin errors++; $display("FAIL rv_en_count got %0d exp 8", en_q.size()); end
    for (int i = 0; i < en_q.size(); i++) begin
      checks++;
      if (en_q[i] != i || vin_q[i] !== i * 32'h1111) begin
        errors++; $display("FAIL rv_reg%0d got idx %0d vin %h exp %h", i, en_q[i], vin_q[i], i * 32'h1111);
      end
    end
  endtask

  task automatic test_restore_invalid();
    Backup_req = 1'b1; step(); Backup_req = 1'b0;
    step();
    Pwr_off = 1'b1; step(); Pwr_off = 1'b0;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL pwroff_outs got %h exp 0", outs); end
    clr();
    Restore_req = 1'b1; step(); Restore_req = 1'b0;
    repeat (5) step();
    checks++;
    if (busy_cnt !== 1 || rdone_cnt !== 1) begin
      errors++; $display("FAIL ri_busy_done got %0d %0d exp 1 1", busy_cnt, rdone_cnt);
    end
    checks++;
    if (en_q.size() != 0 || Restore_valid !== 1'b0) begin
      errors++; $display("FAIL ri_en_valid got %0d %b exp 0 0", en_q.size(), Restore_valid);
    end
  endtask

  task automatic test_stall_backup();
    stall = 1'b1;
    Dirty_val = 16'h0C10;
    for (int i = 0; i < NREG; i++) Backup_Vout[N*i +: N] = 32'hB000_0000 + i;
    clr();
    Backup_req = 1'b1; step(); Backup_req = 1'b0;
    repeat (29) step();
    checks++;
    if (busy_cnt !== 24) begin errors++; $display("FAIL stall_busy got %0d exp 24", busy_cnt); end
    checks++;
    if (ack_q.size() != 2 || ack_q[0] != 2 || ack_q[1] != 5 || bdone_cnt != 1) begin
      errors++; $display("FAIL stall_ack got %p exp 2,5", ack_q);
    end
  endtask

  task automatic test_combo_pwroff();
    clr();
    Backup_req = 1'b1; Restore_req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) begin Backup_req = 1'b0; Restore_req = 1'b0; end
      if (c <= 4) begin
        checks++;
        if ({Nvm_req, Nvm_we, Nvm_addr, Backup_en} !== {1'b1, 1'b0, 4'd8, 1'b0}) begin
          errors++; $display("FAIL combo_check_c%0d got %b", c, {Nvm_req, Nvm_we, Nvm_addr, Backup_en});
        end
      end else if (c <= 8) begin
        checks++;
        if ({Nvm_req, Nvm_we, Nvm_addr} !== {1'b1, 1'b0, 4'd0}) begin
          errors++; $display("FAIL combo_read0_c%0d got %b", c, {Nvm_req, Nvm_we, Nvm_addr});
        end
      end else if (c == 9) begin
        checks++;
        if (Restore_en !== 8'h01 || Restore_Vin !== 32'h0) begin
          errors++; $display("FAIL combo_en0 got %h %h exp 01 0", Restore_en, Restore_Vin);
        end
      end else if (c == 13) begin
        checks++;
        if (Restore_en !== 8'h02 || Restore_Vin !== 32'h1111) begin
          errors++; $display("FAIL combo_en1 got %h %h exp 02 1111", Restore_en, Restore_Vin);
        end
      end
    end
    Pwr_off = 1'b1; step(); Pwr_off = 1'b0;
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL combo_pwroff_outs got %h exp 0", outs); end
    stall = 1'b0;
  endtask

  initial begin
    multi_hot = 0;
    test_reset();
    test_reset_mid_write();
    test_backup_two_dirty();
    test_all_clean();
    test_backup_all();
    test_restore_valid();
    test_restore_invalid();
    test_stall_backup();
    test_combo_pwroff();
    checks++;
    if (multi_hot != 0) begin errors++; $display("FAIL onehot got %0d multi-hot cycles exp 0", multi_hot); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
